// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle main control FSM for the MIPS-subset datapath.
// Moore controls per state, memory-ready stalls, a sticky invalid-opcode
// flag and a retired-instruction counter.
module unidade_controle_multiciclo #(
   parameter int LARGURA_CONT = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [5:0]              opcode,
   input  logic                    mem_pronta,
   output logic                    pc_write,
   output logic                    pc_write_cond,
   output logic                    i_or_d,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic                    ir_write,
   output logic                    mem_to_reg,
   output logic                    reg_dst,
   output logic                    reg_write,
   output logic                    alu_src_a,
   output logic [1:0]              alu_src_b,
   output logic [1:0]              alu_op,
   output logic [1:0]              pc_source,
   output logic [3:0]              estado,
   output logic                    erro_opcode,
   output logic [LARGURA_CONT-1:0] contador_instrucoes
);

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXEC_R    = 4'd6,
      R_WB      = 4'd7,
      BRANCH    = 4'd8,
      JUMP      = 4'd9,
      ADDI_EXEC = 4'd10,
      ADDI_WB   = 4'd11
   } estado_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   estado_t atual, proximo;
   logic    op_invalido;
   logic    retira;
   logic    pc_write_i, pc_write_cond_i, mem_write_i, ir_write_i, reg_write_i;

   // State register, sticky error flag and retired-instruction counter.
   always_ff @(posedge clock) begin
      if (!reset) begin
         atual               <= FETCH;
         erro_opcode         <= 1'b0;
         contador_instrucoes <= '0;
      end else begin
         atual <= proximo;
         if (op_invalido)
            erro_opcode <= 1'b1;
         if (retira)
            contador_instrucoes <= contador_instrucoes + 1'b1;
      end
   end

   // Next-state decode; also flags decode of an unknown opcode and retirement.
   always_comb begin
      proximo     = FETCH;
      op_invalido = 1'b0;
      retira      = 1'b0;
      case (atual)
         FETCH:     proximo = mem_pronta ? DECODE : FETCH;
         DECODE: begin
            case (opcode)
               OP_R:          proximo = EXEC_R;
               OP_LW, OP_SW:  proximo = MEM_ADDR;
               OP_BEQ:        proximo = BRANCH;
               OP_J:          proximo = JUMP;
               OP_ADDI:       proximo = ADDI_EXEC;
               default: begin
                  proximo     = FETCH;
                  op_invalido = 1'b1;
               end
            endcase
         end
         MEM_ADDR:  proximo = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
         MEM_READ:  proximo = mem_pronta ? MEM_WB : MEM_READ;
         MEM_WB:    begin proximo = FETCH; retira = 1'b1; end
         MEM_WRITE: begin
            proximo = mem_pronta ? FETCH : MEM_WRITE;
            retira  = mem_pronta;
         end
         EXEC_R:    proximo = R_WB;
         R_WB:      begin proximo = FETCH; retira = 1'b1; end
         BRANCH:    begin proximo = FETCH; retira = 1'b1; end
         JUMP:      begin proximo = FETCH; retira = 1'b1; end
         ADDI_EXEC: proximo = ADDI_WB;
         ADDI_WB:   begin proximo = FETCH; retira = 1'b1; end
         default:   proximo = FETCH;
      endcase
   end

   // Per-state datapath controls; FETCH only latches IR/PC once memory answers.
   always_comb begin
      pc_write_i      = 1'b0;
      pc_write_cond_i = 1'b0;
      i_or_d          = 1'b0;
      mem_read        = 1'b0;
      mem_write_i     = 1'b0;
      ir_write_i      = 1'b0;
      mem_to_reg      = 1'b0;
      reg_dst         = 1'b0;
      reg_write_i     = 1'b0;
      alu_src_a       = 1'b0;
      alu_src_b       = 2'b00;
      alu_op          = 2'b00;
      pc_source       = 2'b00;
      case (atual)
         FETCH: begin
            mem_read   = 1'b1;
            alu_src_b  = 2'b01;
            ir_write_i = mem_pronta;
            pc_write_i = mem_pronta;
         end
         DECODE:    alu_src_b = 2'b11;
         MEM_ADDR:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
         MEM_READ:  begin mem_read = 1'b1; i_or_d = 1'b1; end
         MEM_WB:    begin reg_write_i = 1'b1; mem_to_reg = 1'b1; end
         MEM_WRITE: begin mem_write_i = 1'b1; i_or_d = 1'b1; end
         EXEC_R:    begin alu_src_a = 1'b1; alu_op = 2'b10; end
         R_WB:      begin reg_dst = 1'b1; reg_write_i = 1'b1; end
         BRANCH: begin
            alu_src_a       = 1'b1;
            alu_op          = 2'b01;
            pc_write_cond_i = 1'b1;
            pc_source       = 2'b01;
         end
         JUMP:      begin pc_write_i = 1'b1; pc_source = 2'b10; end
         ADDI_EXEC: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
         ADDI_WB:   reg_write_i = 1'b1;
         default:   ;
      endcase
   end

   // Write enables are held off for as long as reset is asserted.
   assign pc_write      = pc_write_i      & reset;
   assign pc_write_cond = pc_write_cond_i & reset;
   assign mem_write     = mem_write_i     & reset;
   assign ir_write      = ir_write_i      & reset;
   assign reg_write     = reg_write_i     & reset;
   assign estado        = atual;

endmodule
